// File: rtl/optical_pkg.sv
// Shared optical-link definitions: TX framer state encoding, SYNC byte and CRC8 constants.
// The RX-side checker imports the same constants so both ends agree on the frame CRC.
package optical_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAY,
        CRC
    } framer_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h7E;
    localparam logic [7:0] CRC8_POLY     = 8'h1D;
    localparam logic [7:0] CRC8_INIT     = 8'hFF;
    localparam logic [7:0] CRC8_XOR_OUT  = 8'h00;
    localparam bit         CRC8_REF_IN   = 1'b1;
    localparam bit         CRC8_REF_OUT  = 1'b1;

endpackage

// File: rtl/crc_calc.sv
// crc_calc: generic bytewise CRC engine, one DATA_WIDTH word folded in per valid_i cycle.
// Latency: crc_o reflects a word the cycle after it is fed (register output).
// Backpressure: none; the caller gates valid_i, and crc_o holds while valid_i is low.
module crc_calc #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  CRC_SIZE   = 8,
    parameter logic [CRC_SIZE-1:0] POLY       = 8'h1D,
    parameter logic [CRC_SIZE-1:0] INIT       = 8'hFF,
    parameter bit                  REF_IN     = 1'b1,
    parameter bit                  REF_OUT    = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [CRC_SIZE-1:0] crc_q;

    // MSB-first shift register; reflected input is handled by walking data bits LSB-first.
    function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c,
                                                     input logic [DATA_WIDTH-1:0] d);
        logic [CRC_SIZE-1:0] r;
        logic                fb;
        r = c;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[CRC_SIZE-1] ^ (REF_IN ? d[DATA_WIDTH-1-i] : d[i]);
            r  = {r[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_SIZE-1:0] reflect(input logic [CRC_SIZE-1:0] c);
        logic [CRC_SIZE-1:0] r;
        for (int i = 0; i < CRC_SIZE; i++) begin
            r[i] = c[CRC_SIZE-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_reset_i) begin
            crc_q <= INIT;
        end else if (valid_i) begin
            crc_q <= crc_step(crc_q, data_i);
        end
    end

    assign crc_o = (REF_OUT ? reflect(crc_q) : crc_q) ^ XOR_OUT;

endmodule

// File: rtl/crc8_tx_framer.sv
// crc8_tx_framer: wraps a payload stream into SYNC|LEN|PAYLOAD|CRC8; CRC8_TX_FRAMER_STATS_EN adds frame_cnt_o.
// Latency: SYNC offered the cycle after start_i; payload bytes pass through combinationally.
// Backpressure: every state advances only on m_valid_o & m_ready_i; in PAY m_ready_i drives s_ready_o.
module crc8_tx_framer
    import optical_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0] CRC_POLY  = CRC8_POLY,
    parameter logic [7:0] CRC_INIT  = CRC8_INIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  len_i,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    output logic        m_valid_o,
    output logic [7:0]  m_data_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        busy_o
`ifdef CRC8_TX_FRAMER_STATS_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    framer_state_e state_q, state_d;
    logic [7:0]    len_q;
    logic [7:0]    cnt_q;
    logic [7:0]    crc;
    logic          hs;
    logic          crc_soft_rst;
    logic          crc_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                len_q <= len_i;
                cnt_q <= len_i;
            end else if (state_q == PAY && hs) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        m_valid_o = 1'b0;
        m_data_o  = 8'd0;
        m_last_o  = 1'b0;
        s_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = SYNC;
            end
            SYNC: begin
                m_valid_o = 1'b1;
                m_data_o  = SYNC_BYTE;
                if (m_ready_i) state_d = LEN;
            end
            LEN: begin
                m_valid_o = 1'b1;
                m_data_o  = len_q;
                if (m_ready_i) state_d = (len_q != 8'd0) ? PAY : CRC;
            end
            PAY: begin
                m_valid_o = s_valid_i;
                m_data_o  = s_data_i;
                s_ready_o = m_ready_i;
                if (s_valid_i && m_ready_i && cnt_q == 8'd1) state_d = CRC;
            end
            CRC: begin
                m_valid_o = 1'b1;
                m_data_o  = crc;
                m_last_o  = 1'b1;
                if (m_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs     = m_valid_o & m_ready_i;
    assign busy_o = (state_q != IDLE);

    // A fresh frame restarts the CRC in the same cycle start_i is accepted.
    assign crc_soft_rst = (state_q == IDLE) && start_i;
    assign crc_vld      = hs && (state_q == LEN || state_q == PAY);

    crc_calc #(
        .DATA_WIDTH (8),
        .CRC_SIZE   (8),
        .POLY       (CRC_POLY),
        .INIT       (CRC_INIT),
        .REF_IN     (CRC8_REF_IN),
        .REF_OUT    (CRC8_REF_OUT),
        .XOR_OUT    (CRC8_XOR_OUT)
    ) u_crc (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .soft_reset_i (crc_soft_rst),
        .valid_i      (crc_vld),
        .data_i       (m_data_o),
        .crc_o        (crc)
    );

`ifdef CRC8_TX_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= 16'd0;
        end else if (state_q == CRC && hs) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
